// File: rtl/dcc_frame_writer.sv
// Double-buffered frame packer feeding the HPS PIO read path.
// Fills a shadow bank, then hands it to the display bank once the HPS acknowledges.
`timescale 1ns/1ps
module dcc_frame_writer #(
    parameter int          NWORDS      = 32,
    parameter int          TIMEOUT_CYC = 50_000_000,
    parameter logic [31:0] PAD_WORD    = 32'hFFFF_FFFF
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset,
    input  logic                   in_valid,
    input  logic [31:0]            in_data,
    output logic                   in_ready,
    input  logic [25:0]            pps_time_in,
    input  logic [31:0]            pps_count_in,
    input  logic                   hps_read_bit,
    output logic [NWORDS*32-1:0]   dcc_data,
    output logic [25:0]            dcc_time_out,
    output logic [31:0]            pps_count_out,
    output logic                   frame_pending,
    output logic [7:0]             frame_seq,
    output logic [15:0]            drop_count
);

    localparam int AW = $clog2(NWORDS);
    localparam int LW = AW + 1;
    localparam int IW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [LW-1:0] LAST     = LW'(NWORDS - 1);
    localparam logic [LW-1:0] FULL_LEN = LW'(NWORDS);
    localparam logic [IW-1:0] IDLE_MAX = IW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic {FILL, FULL} state_e;

    state_e                   state_q, state_d;
    logic [LW-1:0]            wr_idx_q, wr_idx_d;
    logic [LW-1:0]            len_q, len_d;
    logic [IW-1:0]            idle_q, idle_d;
    logic [NWORDS-1:0][31:0]  shadow_q;
    logic [NWORDS-1:0][31:0]  disp_q, disp_d;
    logic [25:0]              time_q, time_d;
    logic [31:0]              cnt_q, cnt_d;
    logic                     pend_q, pend_d;
    logic [7:0]               seq_q, seq_d;
    logic [15:0]              drop_q, drop_d;
    logic                     ack_q;
    logic                     accept, toggle, xfer;

    assign in_ready      = (state_q == FILL);
    assign accept        = in_valid & in_ready;
    assign toggle        = hps_read_bit ^ ack_q;
    assign dcc_data      = disp_q;
    assign dcc_time_out  = time_q;
    assign pps_count_out = cnt_q;
    assign frame_pending = pend_q;
    assign frame_seq     = seq_q;
    assign drop_count    = drop_q;

    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        len_d    = len_q;
        idle_d   = idle_q;
        disp_d   = disp_q;
        time_d   = time_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        seq_d    = seq_q;
        drop_d   = drop_q;
        xfer     = 1'b0;

        unique case (state_q)
            FILL: begin
                if (accept) begin
                    idle_d   = '0;
                    wr_idx_d = wr_idx_q + 1'b1;
                    if (wr_idx_q == LAST) begin
                        state_d = FULL;
                        len_d   = FULL_LEN;
                    end
                end else if (TIMEOUT_CYC != 0 && wr_idx_q != '0) begin
                    if (idle_q == IDLE_MAX) begin
                        state_d = FULL;
                        len_d   = wr_idx_q;
                        idle_d  = '0;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
            end
            FULL: begin
                // Pending is the registered value; an ack this cycle frees the next one.
                if (!pend_q) begin
                    xfer     = 1'b1;
                    state_d  = FILL;
                    wr_idx_d = '0;
                end
            end
        endcase

        if (xfer) begin
            for (int i = 0; i < NWORDS; i++) begin
                disp_d[i] = (LW'(i) < len_q) ? shadow_q[i] : PAD_WORD;
            end
            time_d = pps_time_in;
            cnt_d  = pps_count_in;
            seq_d  = seq_q + 8'd1;
            pend_d = 1'b1;
        end else if (toggle) begin
            pend_d = 1'b0;
        end

        if (in_valid && !in_ready && drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (accept) begin
            shadow_q[wr_idx_q[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q  <= FILL;
            wr_idx_q <= '0;
            len_q    <= '0;
            idle_q   <= '0;
            disp_q   <= '0;
            time_q   <= '0;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            seq_q    <= '0;
            drop_q   <= '0;
            ack_q    <= hps_read_bit;
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            len_q    <= len_d;
            idle_q   <= idle_d;
            disp_q   <= disp_d;
            time_q   <= time_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            seq_q    <= seq_d;
            drop_q   <= drop_d;
            ack_q    <= hps_read_bit;
        end
    end

endmodule

// File: tb/tb_dcc_frame_writer.sv
// Directed scoreboard bench for dcc_frame_writer (NWORDS=32, TIMEOUT_CYC=100).
`timescale 1ns/1ps
module tb_dcc_frame_writer;

    localparam int NW = 32;
    localparam logic [31:0] PAD = 32'hFFFF_FFFF;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [31:0]       in_data;
    logic              in_ready;
    logic [25:0]       pps_time_in;
    logic [31:0]       pps_count_in;
    logic              hps;
    logic [NW*32-1:0]  dcc_data;
    logic [25:0]       dcc_time_out;
    logic [31:0]       pps_count_out;
    logic              frame_pending;
    logic [7:0]        frame_seq;
    logic [15:0]       drop_count;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    dcc_frame_writer #(.NWORDS(NW), .TIMEOUT_CYC(100), .PAD_WORD(PAD)) dut (
        .clk_clk       (clk),
        .reset_reset   (rst),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .pps_time_in   (pps_time_in),
        .pps_count_in  (pps_count_in),
        .hps_read_bit  (hps),
        .dcc_data      (dcc_data),
        .dcc_time_out  (dcc_time_out),
        .pps_count_out (pps_count_out),
        .frame_pending (frame_pending),
        .frame_seq     (frame_seq),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] w, input logic exp_rdy);
        in_valid = 1'b1;
        in_data  = w;
        chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
        if (exp_rdy) exp_q.push_back(w);
        tick();
    endtask

    task automatic check_frame(input int nvalid);
        logic [31:0] e;
        for (int i = 0; i < NW; i++) begin
            if (i < nvalid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $error("FAIL sb_empty: word %0d has no expected value", i);
                    continue;
                end
                e = exp_q.pop_front();
            end else begin
                e = PAD;
            end
            chk($sformatf("word%0d", i), {32'd0, dcc_data[32*i +: 32]}, {32'd0, e});
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_data"}, {63'd0, (dcc_data === '0)}, 64'd1);
        chk({tag, "_time"}, {38'd0, dcc_time_out}, 64'd0);
        chk({tag, "_cnt"}, {32'd0, pps_count_out}, 64'd0);
        chk({tag, "_pend"}, {63'd0, frame_pending}, 64'd0);
        chk({tag, "_seq"}, {56'd0, frame_seq}, 64'd0);
        chk({tag, "_drop"}, {48'd0, drop_count}, 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        pps_time_in = '0;
        pps_count_in = '0;
        hps = 1'b0;
        tick();
        tick();
        check_zero("reset");
        rst = 1'b0;
        tick();

        // Frame 1: words 0..31 back to back
        for (int i = 0; i < NW; i++) begin
            pps_time_in = 26'(i);
            send(32'(i), 1'b1);
        end
        in_valid = 1'b0;
        pps_time_in = 26'h123456;
        pps_count_in = 32'hCAFE0001;
        chk("seq_before_xfer", {56'd0, frame_seq}, 64'd0);
        tick();
        check_frame(NW);
        chk("f1_seq", {56'd0, frame_seq}, 64'd1);
        chk("f1_pend", {63'd0, frame_pending}, 64'd1);
        chk("f1_time", {38'd0, dcc_time_out}, 64'h123456);
        chk("f1_cnt", {32'd0, pps_count_out}, 64'hCAFE0001);
        pps_time_in = 26'h0000AA;
        tick();
        chk("time_stable", {38'd0, dcc_time_out}, 64'h123456);

        // Frame 2 fills while frame 1 is pending, then stalls
        for (int i = 32; i < 64; i++) send(32'(i), 1'b1);
        repeat (5) send(32'd64, 1'b0);
        chk("drop5", {48'd0, drop_count}, 64'd5);
        chk("disp_hold", {32'd0, dcc_data[31:0]}, 64'd0);
        hps = ~hps;
        send(32'd64, 1'b0);
        chk("ack_pend", {63'd0, frame_pending}, 64'd0);
        chk("ack_seq", {56'd0, frame_seq}, 64'd1);
        send(32'd64, 1'b0);
        check_frame(NW);
        chk("f2_seq", {56'd0, frame_seq}, 64'd2);
        chk("f2_pend", {63'd0, frame_pending}, 64'd1);
        chk("drop7", {48'd0, drop_count}, 64'd7);

        // Partial frame of 5 words flushed by the idle timeout
        for (int i = 64; i < 69; i++) send(32'(i), 1'b1);
        in_valid = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (k == 10) hps = ~hps;
            tick();
        end
        chk("no_early_flush", {56'd0, frame_seq}, 64'd2);
        tick();
        chk("f3_seq", {56'd0, frame_seq}, 64'd3);
        check_frame(5);
        chk("f3_time", {38'd0, dcc_time_out}, 64'hAA);

        // Ack, then a spurious toggle with nothing pending
        hps = ~hps;
        tick();
        chk("ack3_pend", {63'd0, frame_pending}, 64'd0);
        hps = ~hps;
        pps_time_in = 26'h0000BB;
        tick();
        chk("spur_pend", {63'd0, frame_pending}, 64'd0);
        chk("spur_seq", {56'd0, frame_seq}, 64'd3);
        chk("spur_word5", {32'd0, dcc_data[32*5 +: 32]}, {32'd0, PAD});
        chk("spur_time", {38'd0, dcc_time_out}, 64'hAA);
        chk("spur_rdy", {63'd0, in_ready}, 64'd1);

        // Frame 4, then frame 5 whose FULL cycle coincides with the ack
        for (int i = 100; i < 132; i++) send(32'(i), 1'b1);
        in_valid = 1'b0;
        tick();
        check_frame(NW);
        chk("f4_seq", {56'd0, frame_seq}, 64'd4);
        for (int i = 200; i < 232; i++) send(32'(i), 1'b1);
        in_valid = 1'b0;
        hps = ~hps;
        tick();
        chk("coinc_seq", {56'd0, frame_seq}, 64'd4);
        chk("coinc_pend", {63'd0, frame_pending}, 64'd0);
        tick();
        chk("f5_seq", {56'd0, frame_seq}, 64'd5);
        chk("f5_pend", {63'd0, frame_pending}, 64'd1);
        check_frame(NW);

        // Reset in the middle of a fill
        for (int i = 300; i < 317; i++) send(32'(i), 1'b1);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        exp_q.delete();
        check_zero("midrst");
        rst = 1'b0;
        tick();

        // 256 frames, sequence number wraps
        for (int f = 0; f < 256; f++) begin
            for (int i = 0; i < NW; i++) send(32'(f * 32 + i), 1'b1);
            in_valid = 1'b0;
            tick();
            check_frame(NW);
            chk("loop_seq", {56'd0, frame_seq}, {56'd0, 8'(f + 1)});
            hps = ~hps;
            tick();
        end
        chk("seq_wrap", {56'd0, frame_seq}, 64'd0);
        chk("loop_drop", {48'd0, drop_count}, 64'd0);

        // Long stall saturates the drop counter
        for (int i = 0; i < NW; i++) send(32'(i + 1000), 1'b1);
        in_valid = 1'b0;
        tick();
        chk("sat_pend", {63'd0, frame_pending}, 64'd1);
        in_valid = 1'b1;
        repeat (70000) tick();
        chk("drop_sat", {48'd0, drop_count}, 64'hFFFF);
        chk("sat_rdy", {63'd0, in_ready}, 64'd0);
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
